// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount frame accumulator: FSM encoding,
// legal per-byte count ceiling and default datapath widths.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int CNT_MAX   = 8;
    localparam int SUM_W_DEF = 16;
    localparam int LEN_W_DEF = 8;

    // Counts above the legal ceiling contribute as the ceiling itself.
    function automatic logic [7:0] clamp_cnt(input logic [7:0] cnt);
        logic [7:0] res;
        if (cnt > 8'd8) begin
            res = 8'd8;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/popcount_frame_acc_sat_add.sv
// Saturating W-bit adder: clips to all-ones on carry-out and flags it.
module sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    // Wide add, then clip on carry.
    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = full[W];
        if (full[W]) begin
            sum = {W{1'b1}};
        end else begin
            sum = full[W-1:0];
        end
    end

endmodule

// File: rtl/popcount_frame_acc.sv
// Per-frame ones-count accumulator with a one-entry valid/ready summary buffer.
// Optional FRAME_ACC_HOT_EN adds a registered out_hot (final sum >= HOT_THRESH).
module popcount_frame_acc
    import popcount_pkg::*;
#(
    parameter int SUM_W      = SUM_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int MAX_LEN    = 255,
    parameter int HOT_THRESH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_cnt,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_len,
    output logic [7:0]       out_max,
    output logic             out_err,
    output logic             out_hot
);

    if (MAX_LEN > (1 << LEN_W) - 1 || MAX_LEN < 1 || HOT_THRESH < 0 || SUM_W <= 8) begin : g_bad_params
        $error("popcount_frame_acc: illegal parameter combination");
    end

    state_t             state;
    state_t             next_state;
    logic [SUM_W-1:0]   acc_sum;
    logic [LEN_W-1:0]   acc_len;
    logic [7:0]         acc_max;
    logic               acc_err;

    logic               accept;
    logic [7:0]         cnt_c;
    logic               cnt_bad;
    logic [SUM_W-1:0]   base_sum;
    logic [LEN_W-1:0]   base_len;
    logic [7:0]         base_max;
    logic               base_err;
    logic [SUM_W-1:0]   new_sum;
    logic               sum_ovf;
    logic [LEN_W-1:0]   new_len;
    logic [7:0]         new_max;
    logic               forced;
    logic               new_err;
    logic               frame_end;

    assign accept  = in_valid && in_ready;
    assign cnt_c   = clamp_cnt(in_cnt);
    assign cnt_bad = (in_cnt > 8'd8);

    // A frame starts from zero in IDLE, so the same datapath serves load and accumulate.
    always_comb begin
        if (state == ACC) begin
            base_sum = acc_sum;
            base_len = acc_len;
            base_max = acc_max;
            base_err = acc_err;
        end else begin
            base_sum = {SUM_W{1'b0}};
            base_len = {LEN_W{1'b0}};
            base_max = 8'd0;
            base_err = 1'b0;
        end
    end

    sat_add #(.W(SUM_W)) u_sat_add (
        .a   (base_sum),
        .b   ({{(SUM_W-8){1'b0}}, cnt_c}),
        .sum (new_sum),
        .ovf (sum_ovf)
    );

    // Update candidates for this byte and frame-termination decision.
    always_comb begin
        new_len = base_len + {{(LEN_W-1){1'b0}}, 1'b1};
        if (cnt_c > base_max) begin
            new_max = cnt_c;
        end else begin
            new_max = base_max;
        end
        forced    = (new_len == LEN_W'(MAX_LEN));
        new_err   = base_err | cnt_bad | sum_ovf | forced;
        frame_end = in_last | forced;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, ACC: begin
                if (accept) begin
                    next_state = frame_end ? HOLD : ACC;
                end else begin
                    next_state = state;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end else begin
                    next_state = HOLD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Accumulators, handshake flags and the summary buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc_sum   <= {SUM_W{1'b0}};
            acc_len   <= {LEN_W{1'b0}};
            acc_max   <= 8'd0;
            acc_err   <= 1'b0;
            out_sum   <= {SUM_W{1'b0}};
            out_len   <= {LEN_W{1'b0}};
            out_max   <= 8'd0;
            out_err   <= 1'b0;
        end else begin
            in_ready  <= (next_state != HOLD);
            out_valid <= (next_state == HOLD);
            if (accept) begin
                acc_sum <= new_sum;
                acc_len <= new_len;
                acc_max <= new_max;
                acc_err <= new_err;
                if (frame_end) begin
                    out_sum <= new_sum;
                    out_len <= new_len;
                    out_max <= new_max;
                    out_err <= new_err;
                end
            end
        end
    end

`ifdef FRAME_ACC_HOT_EN
    // Hot flag travels with the summary and drops when the buffer drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_hot <= 1'b0;
        end else if (accept && frame_end) begin
            out_hot <= (new_sum >= SUM_W'(HOT_THRESH));
        end else if (state == HOLD && out_ready) begin
            out_hot <= 1'b0;
        end
    end
`else
    assign out_hot = 1'b0;
`endif

endmodule
